// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential Booth multiplier, one partial-product step per clock.
// Operands are extended to EXT = REG_WIDTH+2 bits (sign or zero) so that signed
// and unsigned modes share one signed datapath.
// Optional feature macro: BOOTH_RADIX4_EN selects modified Booth radix-4 recoding
// (two bits per step, half the iterations); default build is radix-2.
module booth_multiplier #(
    parameter int REG_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     ctl_signed,
    input  logic [REG_WIDTH-1:0]     input_a,
    input  logic [REG_WIDTH-1:0]     input_b,
    output logic                     busy,
    output logic                     done,
    output logic [2*REG_WIDTH-1:0]   product
);

    localparam int EXT = REG_WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = EXT / 2;
`else
    localparam int ITER = EXT;
`endif
    localparam int CW = $clog2(ITER + 1);

    // Elaboration-time parameter checks.
    if (REG_WIDTH < 2) begin : g_chk_width
        $error("booth_multiplier: REG_WIDTH must be >= 2");
    end
`ifdef BOOTH_RADIX4_EN
    if ((REG_WIDTH % 2) != 0) begin : g_chk_even
        $error("booth_multiplier: REG_WIDTH must be even for radix-4");
    end
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;

    // Datapath registers: multiplicand, accumulator (one guard bit so -A and
    // -2A never overflow), multiplier/low product half, and the Booth q_-1 bit.
    logic [EXT-1:0]  a_reg;
    logic [EXT:0]    acc;
    logic [EXT-1:0]  q_reg;
    logic            q_m1;
    logic [CW-1:0]   cnt;

    logic [EXT-1:0]  a_load, b_load;
    logic            load;
    logic            last_iter;

    logic [EXT:0]    a_ext;
    logic [EXT:0]    acc_sum;
    logic [EXT:0]    acc_nxt;
    logic [EXT-1:0]  q_nxt;
    logic            q_m1_nxt;
    logic [2*EXT:0]  full_nxt;

    // Operand extension at load: sign-extend in signed mode, zero-extend otherwise.
    always_comb begin
        if (ctl_signed) begin
            a_load = {{2{input_a[REG_WIDTH-1]}}, input_a};
            b_load = {{2{input_b[REG_WIDTH-1]}}, input_b};
        end else begin
            a_load = {2'b00, input_a};
            b_load = {2'b00, input_b};
        end
    end

    // A new operation is accepted only while not calculating.
    assign load      = start && (state != S_CALC);
    assign last_iter = (state == S_CALC) && (cnt == CW'(1));
    assign a_ext     = {a_reg[EXT-1], a_reg};

`ifdef BOOTH_RADIX4_EN
    logic [EXT:0] two_a;
    assign two_a = {a_reg, 1'b0};

    // Radix-4 step: recode {Q[1:0],q_-1}, add 0/+-A/+-2A, shift right by two.
    always_comb begin
        acc_sum = acc;
        case ({q_reg[1:0], q_m1})
            3'b001, 3'b010: acc_sum = acc + a_ext;
            3'b011:         acc_sum = acc + two_a;
            3'b100:         acc_sum = acc - two_a;
            3'b101, 3'b110: acc_sum = acc - a_ext;
            default:        acc_sum = acc;
        endcase
        acc_nxt  = {{2{acc_sum[EXT]}}, acc_sum[EXT:2]};
        q_nxt    = {acc_sum[1:0], q_reg[EXT-1:2]};
        q_m1_nxt = q_reg[1];
    end
`else
    // Radix-2 step: recode {Q[0],q_-1}, add 0/+-A, shift right by one.
    always_comb begin
        acc_sum = acc;
        case ({q_reg[0], q_m1})
            2'b10:   acc_sum = acc - a_ext;
            2'b01:   acc_sum = acc + a_ext;
            default: acc_sum = acc;
        endcase
        acc_nxt  = {acc_sum[EXT], acc_sum[EXT:1]};
        q_nxt    = {acc_sum[0], q_reg[EXT-1:1]};
        q_m1_nxt = q_reg[0];
    end
`endif

    assign full_nxt = {acc_nxt, q_nxt};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; DONE may chain straight into a new CALC.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (cnt == CW'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_CALC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_CALC:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load on acceptance, one Booth step per CALC cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            acc   <= '0;
            q_reg <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_reg <= a_load;
            acc   <= '0;
            q_reg <= b_load;
            q_m1  <= 1'b0;
            cnt   <= CW'(ITER);
        end else if (state == S_CALC) begin
            acc   <= acc_nxt;
            q_reg <= q_nxt;
            q_m1  <= q_m1_nxt;
            cnt   <= cnt - CW'(1);
        end
    end

    // Product register: captured from the final step so it is valid in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n)         product <= '0;
        else if (last_iter) product <= full_nxt[2*REG_WIDTH-1:0];
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Testbench for booth_multiplier: directed cases plus randomized operands for
// REG_WIDTH=8 and REG_WIDTH=16, checked against plain integer multiplication.
module tb_booth_multiplier;

`ifdef BOOTH_RADIX4_EN
    localparam int ITER8  = 5;
    localparam int ITER16 = 9;
`else
    localparam int ITER8  = 10;
    localparam int ITER16 = 18;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] product8;

    logic        start16 = 1'b0, sgn16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] product16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    booth_multiplier #(.REG_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ctl_signed(sgn8),
        .input_a(a8), .input_b(b8), .busy(busy8), .done(done8), .product(product8)
    );

    booth_multiplier #(.REG_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .ctl_signed(sgn16),
        .input_a(a16), .input_b(b16), .busy(busy16), .done(done16), .product(product16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact product of w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (64'sd1 <<< w);
        if (s && b[w-1]) sb = sb - (64'sd1 <<< w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [63:0] exp;
        int c;
        exp = ref_mul(s, {24'd0, a}, {24'd0, b}, 8);
        start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
        step();
        start8 = 1'b0;
        c = 1;
        while (!done8 && c < 100) begin step(); c++; end
        chk({tag, "_lat"}, 64'(c), 64'(ITER8 + 1));
        chk({tag, "_prod"}, {48'd0, product8}, exp);
        step();
    endtask

    task automatic run16(input bit s, input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [63:0] exp;
        int c;
        exp = ref_mul(s, {16'd0, a}, {16'd0, b}, 16);
        start16 = 1'b1; sgn16 = s; a16 = a; b16 = b;
        step();
        start16 = 1'b0;
        c = 1;
        while (!done16 && c < 100) begin step(); c++; end
        chk({tag, "_lat"}, 64'(c), 64'(ITER16 + 1));
        chk({tag, "_prod"}, {32'd0, product16}, exp);
        step();
    endtask

    initial begin
        int c, nb, nd;
        logic [15:0] held;

        // Reset state
        rst_n = 1'b0;
        step(); step();
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_done", {63'd0, done8}, 64'd0);
        chk("rst_prod", {48'd0, product8}, 64'd0);
        rst_n = 1'b1;
        step();

        // Directed products
        run8(1'b1, 8'hFD, 8'h05, "s_m3x5");
        chk("s_m3x5_abs", {48'd0, product8}, 64'hFFF1);
        run8(1'b1, 8'h80, 8'h80, "s_m128sq");
        run8(1'b0, 8'hFF, 8'hFF, "u_ffsq");
        run8(1'b0, 8'h80, 8'h02, "u_80x2");

        // Product holds while idle
        held = product8;
        step(); step();
        chk("hold_idle", {48'd0, product8}, {48'd0, held});

        // start during CALC is ignored
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd7; b8 = 8'd9;
        step();
        start8 = 1'b0;
        c = 1;
        nb = busy8 ? 1 : 0;
        while (!done8 && c < 100) begin
            if (c == 3) begin
                start8 = 1'b1; sgn8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
            end
            step();
            start8 = 1'b0;
            c++;
            if (busy8) nb++;
        end
        chk("ign_lat", 64'(c), 64'(ITER8 + 1));
        chk("ign_busy", 64'(nb), 64'(ITER8));
        chk("ign_prod", {48'd0, product8}, 64'd63);
        step();

        // Back-to-back with start held high
        start8 = 1'b1; sgn8 = 1'b1; a8 = 8'd2; b8 = 8'd3;
        step();
        a8 = 8'd7; b8 = 8'hFF;
        c = 1;
        while (!done8 && c < 100) begin step(); c++; end
        chk("b2b1_lat", 64'(c), 64'(ITER8 + 1));
        chk("b2b1_prod", {48'd0, product8}, 64'd6);
        c = 0;
        step(); c++;
        while (!done8 && c < 100) begin step(); c++; end
        start8 = 1'b0;
        chk("b2b2_period", 64'(c), 64'(ITER8 + 1));
        chk("b2b2_prod", {48'd0, product8}, 64'hFFF9);
        step();

        // Reset mid-CALC abandons the operation
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
        step();
        start8 = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_busy", {63'd0, busy8}, 64'd0);
        chk("mid_rst_done", {63'd0, done8}, 64'd0);
        chk("mid_rst_prod", {48'd0, product8}, 64'd0);
        nd = 0;
        repeat (ITER8 + 2) begin step(); if (done8) nd++; end
        chk("mid_rst_nodone", 64'(nd), 64'd0);
        run8(1'b1, 8'h9C, 8'h3B, "after_rst");

        // Randomized, both modes, both widths
        for (int i = 0; i < 2000; i++)
            run8(1'($urandom_range(1)), 8'($urandom), 8'($urandom), "rnd8");
        for (int i = 0; i < 1000; i++)
            run16(1'($urandom_range(1)), 16'($urandom), 16'($urandom), "rnd16");
        run16(1'b1, 16'h8000, 16'h8000, "s16_min_sq");
        run16(1'b0, 16'hFFFF, 16'hFFFF, "u16_max_sq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
